// File: rtl/falafel_lsu_arbiter.sv
// Round-robin arbiter sharing one LSU port between NUM_REQ requesters,
// one transaction outstanding, with exclusive ownership across LOCK/UNLOCK.
module falafel_lsu_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned BLOCK_W = 2 * DATA_W,
  parameter int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [NUM_REQ-1:0]         req_valid_i,
  output logic [NUM_REQ-1:0]         req_ready_o,
  input  logic [NUM_REQ*3-1:0]       req_op_i,
  input  logic [NUM_REQ*DATA_W-1:0]  req_addr_i,
  input  logic [NUM_REQ*BLOCK_W-1:0] req_data_i,
  output logic [NUM_REQ-1:0]         rsp_valid_o,
  output logic [BLOCK_W-1:0]         rsp_data_o,
  output logic                       lsu_req_valid_o,
  input  logic                       lsu_req_ready_i,
  output logic [2:0]                 lsu_op_o,
  output logic [DATA_W-1:0]          lsu_addr_o,
  output logic [BLOCK_W-1:0]         lsu_data_o,
  input  logic                       lsu_rsp_valid_i,
  input  logic [BLOCK_W-1:0]         lsu_rsp_data_i,
  output logic                       lock_held_o,
  output logic [IDX_W-1:0]           lock_owner_o
);

  localparam int unsigned OP_W      = 3;
  localparam logic [OP_W-1:0] OP_LOCK   = 3'd4;
  localparam logic [OP_W-1:0] OP_UNLOCK = 3'd5;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RSP} state_e;

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  grant_q, grant_d;
  logic [IDX_W-1:0]  rr_q, rr_d;
  logic              held_q, held_d;
  logic [IDX_W-1:0]  owner_q, owner_d;
  logic [OP_W-1:0]   cur_op_q, cur_op_d;

  logic [NUM_REQ-1:0] eligible;
  logic               pick_found;
  logic [IDX_W-1:0]   pick_idx;
  int unsigned        cand;
  logic [IDX_W-1:0]   grant_next;

  // Eligible set and first eligible index at or after rr_q, wrapping
  always_comb begin
    eligible   = '0;
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    if (held_q) eligible[owner_q] = req_valid_i[owner_q];
    else        eligible = req_valid_i;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = 32'(rr_q) + i;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!pick_found && eligible[IDX_W'(cand)]) begin
        pick_found = 1'b1;
        pick_idx   = IDX_W'(cand);
      end
    end
  end

  assign grant_next = (32'(grant_q) + 1 >= NUM_REQ) ? '0 : grant_q + IDX_W'(1);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      rr_q     <= '0;
      held_q   <= 1'b0;
      owner_q  <= '0;
      cur_op_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_q     <= rr_d;
      held_q   <= held_d;
      owner_q  <= owner_d;
      cur_op_q <= cur_op_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    grant_d         = grant_q;
    rr_d            = rr_q;
    held_d          = held_q;
    owner_d         = owner_q;
    cur_op_d        = cur_op_q;
    req_ready_o     = '0;
    rsp_valid_o     = '0;
    rsp_data_o      = '0;
    lsu_req_valid_o = 1'b0;
    lsu_op_o        = '0;
    lsu_addr_o      = '0;
    lsu_data_o      = '0;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_d = pick_idx;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        lsu_req_valid_o      = 1'b1;
        lsu_op_o             = req_op_i[32'(grant_q)*OP_W +: OP_W];
        lsu_addr_o           = req_addr_i[32'(grant_q)*DATA_W +: DATA_W];
        lsu_data_o           = req_data_i[32'(grant_q)*BLOCK_W +: BLOCK_W];
        req_ready_o[grant_q] = lsu_req_ready_i;
        if (lsu_req_ready_i) begin
          cur_op_d = lsu_op_o;
          state_d  = WAIT_RSP;
        end
      end
      WAIT_RSP: begin
        rsp_valid_o[grant_q] = lsu_rsp_valid_i;
        rsp_data_o           = lsu_rsp_data_i;
        if (lsu_rsp_valid_i) begin
          state_d = IDLE;
          // Only the owner can be granted while held, so its UNLOCK releases
          if (cur_op_q == OP_LOCK) begin
            held_d  = 1'b1;
            owner_d = grant_q;
          end else if (cur_op_q == OP_UNLOCK && held_q && owner_q == grant_q) begin
            held_d = 1'b0;
          end
          if (!held_d) rr_d = grant_next;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign lock_held_o  = held_q;
  assign lock_owner_o = owner_q;

endmodule

// File: tb/tb_falafel_lsu_arbiter.sv
// Randomized bench for falafel_lsu_arbiter against a transaction-level
// model of round-robin arbitration and lock ownership.
module tb_falafel_lsu_arbiter;

  localparam int unsigned N  = 3;
  localparam int unsigned DW = 64;
  localparam int unsigned BW = 128;
  localparam int unsigned IW = 2;

  localparam logic [2:0] LOAD_WORD  = 3'd0;
  localparam logic [2:0] STORE_WORD = 3'd1;
  localparam logic [2:0] LOAD_BLOCK = 3'd2;
  localparam logic [2:0] LOCK       = 3'd4;
  localparam logic [2:0] UNLOCK     = 3'd5;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*3-1:0]  req_op;
  logic [N*DW-1:0] req_addr;
  logic [N*BW-1:0] req_data;
  logic [N-1:0]    rsp_valid;
  logic [BW-1:0]   rsp_data;
  logic            lsu_req_valid;
  logic            lsu_req_ready;
  logic [2:0]      lsu_op;
  logic [DW-1:0]   lsu_addr;
  logic [BW-1:0]   lsu_data;
  logic            lsu_rsp_valid;
  logic [BW-1:0]   lsu_rsp_data;
  logic            lock_held;
  logic [IW-1:0]   lock_owner;

  falafel_lsu_arbiter #(.NUM_REQ(N), .DATA_W(DW), .BLOCK_W(BW), .IDX_W(IW)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_op_i(req_op),
    .req_addr_i(req_addr), .req_data_i(req_data),
    .rsp_valid_o(rsp_valid), .rsp_data_o(rsp_data),
    .lsu_req_valid_o(lsu_req_valid), .lsu_req_ready_i(lsu_req_ready),
    .lsu_op_o(lsu_op), .lsu_addr_o(lsu_addr), .lsu_data_o(lsu_data),
    .lsu_rsp_valid_i(lsu_rsp_valid), .lsu_rsp_data_i(lsu_rsp_data),
    .lock_held_o(lock_held), .lock_owner_o(lock_owner)
  );

  always #5 clk = ~clk;

  // Requester-side pending requests and reference arbitration state
  bit          p_valid[N];
  logic [2:0]  p_op[N];
  logic [DW-1:0] p_addr[N];
  logic [BW-1:0] p_data[N];
  int          m_rr;
  bit          m_held;
  int          m_owner;

  int n_checks = 0;
  int n_fails  = 0;

  task automatic check(input string tag, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] rand64();
    return {$urandom(), $urandom()};
  endfunction

  function automatic logic [BW-1:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic drive_bus();
    for (int r = 0; r < N; r++) begin
      req_valid[r]           = p_valid[r];
      req_op[r*3 +: 3]       = p_op[r];
      req_addr[r*DW +: DW]   = p_addr[r];
      req_data[r*BW +: BW]   = p_data[r];
    end
  endtask

  task automatic post(input int r, input logic [2:0] op, input logic [DW-1:0] addr, input logic [BW-1:0] data);
    p_valid[r] = 1'b1;
    p_op[r]    = op;
    p_addr[r]  = addr;
    p_data[r]  = data;
    drive_bus();
  endtask

  function automatic int pick();
    for (int i = 0; i < N; i++) begin
      int r = (m_rr + i) % N;
      if (p_valid[r] && (!m_held || r == m_owner)) return r;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_rr = 0;
    m_held = 1'b0;
    m_owner = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int r = 0; r < N; r++) begin
      p_valid[r] = 1'b0; p_op[r] = '0; p_addr[r] = '0; p_data[r] = '0;
    end
    drive_bus();
    lsu_req_ready = 1'b0;
    lsu_rsp_valid = 1'b0;
    lsu_rsp_data  = '0;
    repeat (2) tick();
    rst = 1'b0;
    model_reset();
    check("rst_lsu_req_valid", lsu_req_valid, 0);
    check("rst_lock_held", lock_held, 0);
    check("rst_lock_owner", lock_owner, 0);
    check("rst_req_ready", req_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_lsu_op", lsu_op, 0);
    check("rst_lsu_addr", lsu_addr, 0);
  endtask

  // Posts random new requests, keeping at least one requester eligible
  task automatic fill_requests();
    for (int r = 0; r < N; r++) begin
      if (!p_valid[r] && ($urandom_range(0, 1) == 1)) begin
        logic [2:0] op = 3'($urandom_range(0, 7));
        if (m_held && r == m_owner && $urandom_range(0, 2) == 0) op = UNLOCK;
        post(r, op, rand64(), rand128());
      end
    end
    if (m_held && !p_valid[m_owner])
      post(m_owner, ($urandom_range(0, 1) == 1) ? UNLOCK : 3'($urandom_range(0, 7)), rand64(), rand128());
    if (pick() < 0)
      post($urandom_range(0, N-1), 3'($urandom_range(0, 7)), rand64(), rand128());
  endtask

  // One transaction, starting one cycle into IDLE with requests posted
  task automatic run_txn(input bit abort);
    int w;
    int bp;
    int d;
    logic [BW-1:0] rdata;
    w = pick();
    if (w < 0) return;
    check("idle_lsu_req_valid", lsu_req_valid, 0);
    check("idle_lsu_op", lsu_op, 0);
    check("idle_lsu_addr", lsu_addr, 0);
    lsu_rsp_valid = 1'($urandom_range(0, 1));
    lsu_rsp_data  = rand128();
    lsu_req_ready = 1'($urandom_range(0, 1));
    #1;
    check("idle_stray_rsp_valid", rsp_valid, 0);
    check("idle_req_ready", req_ready, 0);
    tick();
    lsu_rsp_valid = 1'b0;
    lsu_req_ready = 1'b0;
    #1;
    check("issue_lsu_req_valid", lsu_req_valid, 1);
    check("issue_lsu_op", lsu_op, p_op[w]);
    check("issue_lsu_data", lsu_data, p_data[w]);
    bp = $urandom_range(0, 3);
    repeat (bp) begin
      check("bp_req_ready", req_ready, 0);
      check("bp_lsu_addr", lsu_addr, p_addr[w]);
      tick();
      check("bp_lsu_req_valid", lsu_req_valid, 1);
    end
    check("issue_lsu_addr", lsu_addr, p_addr[w]);
    lsu_req_ready = 1'b1;
    #1;
    check("issue_req_ready", req_ready, BW'(1) << w);
    tick();
    p_valid[w] = 1'b0;
    drive_bus();
    lsu_req_ready = 1'b0;
    #1;
    check("wait_lsu_req_valid", lsu_req_valid, 0);
    check("wait_req_ready", req_ready, 0);
    if (abort) begin
      rst = 1'b1;
      for (int r = 0; r < N; r++) p_valid[r] = 1'b0;
      drive_bus();
      tick();
      rst = 1'b0;
      model_reset();
      lsu_rsp_valid = 1'b1;
      lsu_rsp_data  = rand128();
      #1;
      check("late_rsp_valid", rsp_valid, 0);
      check("abort_lock_held", lock_held, 0);
      check("abort_lsu_req_valid", lsu_req_valid, 0);
      tick();
      lsu_rsp_valid = 1'b0;
      #1;
      check("abort_idle_req_valid", lsu_req_valid, 0);
      return;
    end
    d = $urandom_range(0, 2);
    repeat (d) begin
      lsu_req_ready = 1'($urandom_range(0, 1));
      #1;
      check("wait_rsp_valid", rsp_valid, 0);
      check("wait_stray_ready", req_ready, 0);
      tick();
    end
    lsu_req_ready = 1'b0;
    rdata = (p_addr[w][3:0] == 4'h0) ? {64'h40, 64'h80} : rand128();
    lsu_rsp_valid = 1'b1;
    lsu_rsp_data  = rdata;
    #1;
    check("rsp_valid_route", rsp_valid, BW'(1) << w);
    check("rsp_data", rsp_data, rdata);
    tick();
    lsu_rsp_valid = 1'b0;
    if (p_op[w] == LOCK) begin
      m_held = 1'b1;
      m_owner = w;
    end else if (p_op[w] == UNLOCK && m_held && m_owner == w) begin
      m_held = 1'b0;
    end
    if (!m_held) m_rr = (w + 1) % N;
    check("lock_held", lock_held, m_held);
    if (m_held) check("lock_owner", lock_owner, m_owner);
  endtask

  initial begin
    rst = 1'b1;
    req_valid = '0; req_op = '0; req_addr = '0; req_data = '0;
    lsu_req_ready = 1'b0; lsu_rsp_valid = 1'b0; lsu_rsp_data = '0;
    do_reset();

    // Simultaneous loads: requester 0 first, then 1
    post(0, LOAD_WORD, 64'h40, '0);
    post(1, LOAD_WORD, 64'h80, '0);
    run_txn(1'b0);
    run_txn(1'b0);

    // Lock exclusivity: requester 1 locks, requester 0 stalls until UNLOCK
    post(1, LOCK, 64'h18, '0);
    run_txn(1'b0);
    post(0, STORE_WORD, 64'h20, rand128());
    post(1, LOAD_BLOCK, 64'h100, '0);
    run_txn(1'b0);
    post(1, UNLOCK, 64'h18, '0);
    run_txn(1'b0);
    run_txn(1'b0);

    // Unlock while not held is forwarded without lock effect
    post(2, UNLOCK, 64'h8, '0);
    run_txn(1'b0);

    for (int t = 0; t < 200; t++) begin
      fill_requests();
      run_txn(1'b0);
    end

    // Reset during WAIT_RSP with the lock held
    do_reset();
    post(1, LOCK, 64'h18, '0);
    run_txn(1'b0);
    post(1, LOAD_WORD, 64'h40, '0);
    run_txn(1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
